// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front-end. Keeps a fetch pointer, issues in-order read
// requests to instruction ROM (request/grant, in-order response-valid), buffers
// returned words in a small prefetch FIFO and hands them to decode through a
// valid/ready handshake. A redirect flushes the FIFO and discards any words
// still in flight from the old stream.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_redirect       restart fetch at i_redirect_addr
//   i_redirect_addr  new fetch address
//   o_rom_req        ROM read request valid
//   o_rom_addr       ROM read address (stable while o_rom_req is held)
//   i_rom_gnt        ROM accepts the request this cycle
//   i_rom_rvalid     ROM read data valid (in request order, latency >= 1)
//   i_rom_rdata      ROM read data
//   o_instr_valid    o_instr holds a valid instruction
//   i_instr_ready    decode accepts o_instr
//   o_instr          instruction word at FIFO head
//   o_instr_pc       address of o_instr
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic              o_rom_req,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic              i_rom_gnt,
  input  logic              i_rom_rvalid,
  input  logic [DATA_W-1:0] i_rom_rdata,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc
);

  localparam int PW = $clog2(DEPTH);
  // counters must hold the value DEPTH itself
  localparam int CW = PW + 1;
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop;
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_hpc;
  // holds requests off while reset is asserted and for the first cycle after
  logic              r_run;

  logic          w_credit;
  logic          w_issue;
  logic          w_valid;
  logic          w_pop;
  logic          w_drop_resp;
  logic          w_push;
  logic [CW-1:0] w_out_next;

  // credit covers both buffered words and words still in flight, so every
  // granted request is guaranteed a FIFO slot when it returns
  assign w_credit    = ({1'b0, r_count} + {1'b0, r_outstanding}) < CREDIT_LIMIT;
  assign o_rom_req   = r_run & w_credit & ~i_redirect;
  assign o_rom_addr  = r_fpc;
  assign w_issue     = o_rom_req & i_rom_gnt;

  assign w_valid       = (r_count != '0);
  assign o_instr_valid = w_valid;
  assign o_instr       = r_mem[r_rptr];
  assign o_instr_pc    = r_hpc;
  assign w_pop         = w_valid & i_instr_ready;

  // responses belonging to a stream abandoned by redirect are swallowed
  assign w_drop_resp = i_rom_rvalid & (r_drop != '0);
  assign w_push      = i_rom_rvalid & ~w_drop_resp & ~i_redirect;
  assign w_out_next  = r_outstanding + CW'(w_issue) - CW'(i_rom_rvalid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fpc         <= '0;
      r_hpc         <= '0;
      r_run         <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (i_redirect) begin
        // w_issue is 0 here, so w_out_next is the count still in flight
        r_fpc   <= i_redirect_addr;
        r_hpc   <= i_redirect_addr;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_drop  <= w_out_next;
      end else begin
        if (w_issue) begin
          r_fpc <= r_fpc + ADDR_W'(1);
        end
        if (w_drop_resp) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push) begin
          r_mem[r_wptr] <= i_rom_rdata;
          r_wptr        <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
          r_hpc  <= r_hpc + ADDR_W'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // the credit rule makes this unreachable; firing means the credit math broke
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && (r_count == FULL_COUNT)));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end: consumer end of the program-counter address stream.
- Holds its own fetch pointer and issues in-order read requests to instruction ROM over a request/grant + response-valid interface.
- Buffers returned words in a small prefetch FIFO; presents them to the CPU decode stage with a valid/ready handshake.
- On a jump the CPU redirects it; stale prefetched and in-flight words are discarded.

Parameters:
ADDR_W  16  width of instruction addresses
DATA_W  16  width of instruction words
DEPTH   4   prefetch FIFO entries, also the maximum outstanding ROM requests; power of two, at least 2

Ports:
CLK           in   1       clock, rising-edge
RESET         in   1       asynchronous, active-low reset
REDIRECT      in   1       jump or branch taken: restart fetch at REDIRECT_ADDR
REDIRECT_ADDR in   ADDR_W  new fetch address
ROM_REQ       out  1       read request valid
ROM_ADDR      out  ADDR_W  read address, valid while ROM_REQ=1
ROM_GNT       in   1       ROM accepts the request this cycle
ROM_RVALID    in   1       read data valid; responses return in request order, latency 1 or more cycles
ROM_RDATA     in   DATA_W  read data
INSTR_VALID   out  1       INSTR holds a valid instruction
INSTR_READY   in   1       decode accepts INSTR
INSTR         out  DATA_W  instruction word at FIFO head
INSTR_PC      out  ADDR_W  address of INSTR

Behaviour:
- Single clock. RESET is asynchronous and active-low. All state resets to:
  - fetch pointer FPC=0, head pointer HPC=0
  - FIFO empty, outstanding=0, drop=0
  - ROM_REQ=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0
- Fetch pointer FPC:
  - ROM_ADDR = FPC.
  - A request is issued when ROM_REQ=1 and ROM_GNT=1; then FPC increments by 1, modulo 2^ADDR_W (0xFFFF to 0x0000).
- Credit rule:
  - ROM_REQ = (fifo_count + outstanding < DEPTH) and REDIRECT=0.
  - outstanding counts granted requests without a response, including those marked for drop.
  - ROM_REQ depends only on registered state plus REDIRECT; never on ROM_GNT.
  - Once ROM_REQ=1 is raised, ROM_ADDR holds stable until granted or REDIRECT.
- Response handling:
  - Each ROM_RVALID decrements outstanding.
  - If drop>0, the word is discarded and drop decrements.
  - Otherwise the word is pushed into the FIFO.
  - By the credit rule the FIFO cannot overflow; a push into a full FIFO is a design error and must be asserted in simulation.
- CPU side:
  - INSTR_VALID = FIFO not empty.
  - INSTR = head word, INSTR_PC = HPC.
  - A pop occurs when INSTR_VALID and INSTR_READY are both 1; HPC then increments modulo 2^ADDR_W.
  - A push to an empty FIFO is visible the next cycle (1-cycle ROM-response-to-INSTR_VALID latency).
  - Push and pop in the same cycle keep the count unchanged.
- Redirect (REDIRECT=1 at a clock edge) takes priority over everything else:
  - FPC <= REDIRECT_ADDR and HPC <= REDIRECT_ADDR.
  - FIFO flushed to empty.
  - drop <= outstanding after this cycle's response, i.e. outstanding minus ROM_RVALID.
  - Any ROM_RVALID word in the redirect cycle is discarded.
  - No request is issued in the redirect cycle (ROM_REQ=0).
  - A pop handshake in the same cycle still counts as accepted by decode.
  - Fetching at REDIRECT_ADDR starts the next cycle; requests may issue while drop>0.
- Back-to-back REDIRECTs: each reloads the pointers and recomputes drop from the current outstanding count.
- Reset asserted mid-operation clears all state immediately. The ROM must drop pending responses on the same reset.
- Steady-state throughput: 1 instruction/cycle when the ROM grants every cycle and decode is always ready.

Test Plan:
- Reset release, ROM latency 1, always granted, INSTR_READY=1 -> ROM_ADDR 0,1,2,3...; first INSTR_VALID 2 cycles after the first grant with INSTR_PC=0; then 1 instruction/cycle with INSTR_PC incrementing.
- INSTR_READY=0, DEPTH=4 -> exactly 4 grants (addresses 0..3), then ROM_REQ=0 and INSTR_VALID held with INSTR_PC=0; raise READY -> 0..3 drain in order, fetch resumes at 4.
- ROM latency 3 with 3 requests outstanding, REDIRECT to 0x0100 -> the 3 late responses are discarded; the first INSTR after is from 0x0100 with INSTR_PC=0x0100.
- REDIRECT in the same cycle as ROM_RVALID and a pop handshake -> response discarded, FIFO empty next cycle, drop equals remaining outstanding, no stale word reaches INSTR.
- REDIRECT to 0xFFFE -> fetches 0xFFFE, 0xFFFF, 0x0000; INSTR_PC wraps identically.
- RESET pulsed low mid-stream with a random ROM_GNT pattern -> all outputs 0 asynchronously, and fetch restarts from address 0 after release.
